// File: rtl/lisp_heap.sv
// Bump-allocated cons/number heap with a single-port, synchronous-read memory.
// Optional LISP_HEAP_TYPECHECK_EN: reads verify the cell header is a cons first.
module lisp_heap #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int HEAP_BASE  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [DATA_WIDTH-1:0] req_arg0,
    input  logic [DATA_WIDTH-1:0] req_arg1,
    input  logic                  heap_clr,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH:0]   heap_ptr
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [DATA_WIDTH-1:0] TYPE_NUMBER = '0;
    localparam logic [DATA_WIDTH-1:0] TYPE_CONS   = DATA_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   BASE_PTR    = (ADDR_WIDTH+1)'(HEAP_BASE);
    localparam logic [1:0] OP_NUM  = 2'b00;
    localparam logic [1:0] OP_CONS = 2'b01;

    typedef enum logic [3:0] {
        IDLE, W0, W1, W2, RD_HDR, RD_CHK, RD_ADDR, RD_DATA, RESP
    } state_t;

    state_t                  state;
    logic                    op_cons;
    logic                    op_cdr;
    logic                    hdr_bad;
    logic [DATA_WIDTH-1:0]   arg0_q;
    logic [DATA_WIDTH-1:0]   arg1_q;
    logic [ADDR_WIDTH-1:0]   cell_ptr;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   mem_q;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic                    mem_we;

    logic [ADDR_WIDTH+1:0]   alloc_end;
    logic                    full;
    logic                    bad_ptr;

    assign req_ready = rst_n && (state == IDLE) && !heap_clr;

    // Widened by two bits so a cell ending exactly at DEPTH is not mistaken for overflow.
    assign alloc_end = {1'b0, heap_ptr} + (op_cons ? (ADDR_WIDTH+2)'(3) : (ADDR_WIDTH+2)'(2));
    assign full      = alloc_end > (ADDR_WIDTH+2)'(DEPTH);
    assign bad_ptr   = (cell_ptr == '0) || ({1'b0, cell_ptr} >= heap_ptr);

    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = arg0_q;
        mem_addr  = heap_ptr[ADDR_WIDTH-1:0];
        case (state)
            W0: begin
                mem_we    = !full;
                mem_wdata = op_cons ? TYPE_CONS : TYPE_NUMBER;
            end
            W1: begin
                mem_we    = 1'b1;
                mem_addr  = heap_ptr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
                mem_wdata = arg0_q;
            end
            W2: begin
                mem_we    = 1'b1;
                mem_addr  = heap_ptr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(2);
                mem_wdata = arg1_q;
            end
            RD_HDR:  mem_addr = cell_ptr;
            RD_ADDR: mem_addr = cell_ptr + (op_cdr ? ADDR_WIDTH'(2) : ADDR_WIDTH'(1));
            default: ;
        endcase
    end

    // Heap contents deliberately survive reset; only the allocator state is cleared.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_addr] <= mem_wdata;
        mem_q <= mem[mem_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            heap_ptr  <= BASE_PTR;
            op_cons   <= 1'b0;
            op_cdr    <= 1'b0;
            hdr_bad   <= 1'b0;
            arg0_q    <= '0;
            arg1_q    <= '0;
            cell_ptr  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (heap_clr) begin
                        heap_ptr <= BASE_PTR;
                    end else if (req_valid) begin
                        op_cons  <= (req_op == OP_CONS);
                        op_cdr   <= req_op[0];
                        hdr_bad  <= 1'b0;
                        arg0_q   <= req_arg0;
                        arg1_q   <= req_arg1;
                        cell_ptr <= req_arg0[ADDR_WIDTH-1:0];
                        if (req_op == OP_NUM || req_op == OP_CONS)
                            state <= W0;
                        else
`ifdef LISP_HEAP_TYPECHECK_EN
                            state <= RD_HDR;
`else
                            state <= RD_ADDR;
`endif
                    end
                end
                W0: begin
                    if (full) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                    end else begin
                        state <= W1;
                    end
                end
                W1: begin
                    if (op_cons) begin
                        state <= W2;
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_data  <= DATA_WIDTH'(heap_ptr[ADDR_WIDTH-1:0]);
                        heap_ptr  <= heap_ptr + (ADDR_WIDTH+1)'(2);
                    end
                end
                W2: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_data  <= DATA_WIDTH'(heap_ptr[ADDR_WIDTH-1:0]);
                    heap_ptr  <= heap_ptr + (ADDR_WIDTH+1)'(3);
                end
                RD_HDR: begin
                    if (bad_ptr) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                    end else begin
                        state <= RD_CHK;
                    end
                end
                RD_CHK: begin
                    hdr_bad <= (mem_q != TYPE_CONS);
                    state   <= RD_ADDR;
                end
                RD_ADDR: begin
                    if (bad_ptr) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                    end else begin
                        state <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= hdr_bad;
                    rsp_data  <= hdr_bad ? '0 : mem_q;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lisp_heap.sv
// Scoreboard bench for lisp_heap (ADDR_WIDTH=4); a behavioural heap model predicts every response.
module tb_lisp_heap;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int DEPTH = 16;
`ifdef LISP_HEAP_TYPECHECK_EN
    localparam bit TC = 1'b1;
`else
    localparam bit TC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'b00;
    logic [DW-1:0] req_arg0 = '0;
    logic [DW-1:0] req_arg1 = '0;
    logic          heap_clr = 1'b0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic [AW:0]   heap_ptr;

    lisp_heap #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HEAP_BASE(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_arg0(req_arg0), .req_arg1(req_arg1), .heap_clr(heap_clr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .heap_ptr(heap_ptr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            lat;
        int            acc;
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    logic [DW-1:0] model_mem [DEPTH];
    int            model_ptr = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_rsp", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("rsp_data", rsp_data, mon_e.data);
                checkOutput("rsp_err", rsp_err, mon_e.err);
                checkOutput("rsp_latency", cyc - mon_e.acc, mon_e.lat);
            end
        end
    end

    // Predict the response of one request and update the model heap accordingly.
    task automatic predict(input logic [1:0] op, input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                           output exp_t e);
        int size;
        int p;
        e.data = '0;
        e.err  = 1'b0;
        e.acc  = 0;
        if (!op[1]) begin
            size = op[0] ? 3 : 2;
            if (model_ptr + size > DEPTH) begin
                e.err = 1'b1;
                e.lat = 1;
            end else begin
                e.data = DW'(model_ptr);
                e.lat  = size;
                model_mem[model_ptr]     = DW'(op[0]);
                model_mem[model_ptr + 1] = a0;
                if (op[0])
                    model_mem[model_ptr + 2] = a1;
                model_ptr += size;
            end
        end else begin
            p = int'(a0[AW-1:0]);
            if (p == 0 || p >= model_ptr) begin
                e.err = 1'b1;
                e.lat = 1;
            end else if (TC && model_mem[p] != DW'(1)) begin
                e.err = 1'b1;
                e.lat = 4;
            end else begin
                e.data = model_mem[(p + 1 + int'(op[0])) % DEPTH];
                e.lat  = TC ? 4 : 2;
            end
        end
    endtask

    task automatic waitResponse(input exp_t e);
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checkOutput("rsp_timeout", 32'd0, 32'd1);
            sb.delete();
        end
        @(negedge clk);
        checkOutput("heap_ptr", heap_ptr, model_ptr);
        repeat (2) @(negedge clk);
        checkOutput("hold_data", rsp_data, e.data);
        checkOutput("hold_err", rsp_err, e.err);
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [DW-1:0] a0,
                                 input logic [DW-1:0] a1, input bit clr_busy);
        exp_t e;
        int n = 0;
        predict(op, a0, a1, e);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready)
            checkOutput("ready_timeout", 32'd0, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_arg0  = a0;
        req_arg1  = a1;
        @(posedge clk);
        #1;
        e.acc = cyc;
        sb.push_back(e);
        req_valid = 1'b0;
        // Hold heap_clr across the next edge while the block is busy; it must be ignored.
        if (clr_busy) begin
            heap_clr = 1'b1;
            @(posedge clk);
            #1;
            heap_clr = 1'b0;
        end
        @(negedge clk);
        waitResponse(e);
    endtask

    initial begin
        exp_t e;
        foreach (model_mem[i]) model_mem[i] = '0;
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        repeat (2) @(negedge clk);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_rsp_data", rsp_data, 0);
        checkOutput("reset_rsp_err", rsp_err, 0);
        checkOutput("reset_heap_ptr", heap_ptr, 1);
        checkOutput("reset_req_ready", req_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_req_ready", req_ready, 1);

        applyStimulus(2'b00, 16'h002A, 16'h0000, 1'b0);
        checkOutput("mem1_hdr", dut.mem[1], 16'h0000);
        checkOutput("mem2_val", dut.mem[2], 16'h002A);
        applyStimulus(2'b01, 16'h0001, 16'h0000, 1'b0);
        applyStimulus(2'b11, 16'h0003, 16'h0000, 1'b0);
        applyStimulus(2'b10, 16'h0003, 16'h0000, 1'b0);
        applyStimulus(2'b10, 16'h0000, 16'h0000, 1'b0);
        applyStimulus(2'b10, 16'h0006, 16'h0000, 1'b0);
        applyStimulus(2'b10, 16'h0001, 16'h0000, 1'b0);
        applyStimulus(2'b01, 16'h00AA, 16'h00BB, 1'b1);
        applyStimulus(2'b11, 16'hF006, 16'h0000, 1'b0);
        applyStimulus(2'b01, 16'h0005, 16'h0006, 1'b0);
        applyStimulus(2'b00, 16'h1234, 16'h0000, 1'b0);
        applyStimulus(2'b01, 16'h0007, 16'h0008, 1'b0);
        applyStimulus(2'b00, 16'hBEEF, 16'h0000, 1'b0);
        applyStimulus(2'b00, 16'h0001, 16'h0000, 1'b0);
        applyStimulus(2'b10, 16'h000E, 16'h0000, 1'b0);

        // Clear and request in the same idle cycle: clear wins, request goes next cycle.
        heap_clr  = 1'b1;
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_arg0  = 16'h0077;
        #1;
        checkOutput("clr_blocks_ready", req_ready, 0);
        @(posedge clk);
        #1;
        checkOutput("clr_heap_ptr", heap_ptr, 1);
        model_ptr = 1;
        @(negedge clk);
        heap_clr = 1'b0;
        #1;
        checkOutput("ready_after_clr", req_ready, 1);
        predict(2'b00, 16'h0077, 16'h0000, e);
        @(posedge clk);
        #1;
        e.acc = cyc;
        sb.push_back(e);
        req_valid = 1'b0;
        @(negedge clk);
        waitResponse(e);

        // Reset while a cons allocation sits in W1: no response, pointer back to base.
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_arg0  = 16'h0011;
        req_arg1  = 16'h0022;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_heap_ptr", heap_ptr, 1);
        checkOutput("midrst_rsp_valid", rsp_valid, 0);
        checkOutput("midrst_req_ready", req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 1;
        repeat (6) @(negedge clk);
        checkOutput("post_rst_heap_ptr", heap_ptr, 1);
        applyStimulus(2'b00, 16'h0005, 16'h0000, 1'b0);
        applyStimulus(2'b10, 16'h0001, 16'h0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lisp_heap.md
LISP_HEAP -- requirements
Module: lisp_heap

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 12, heap address width; heap depth = 2^ADDR_WIDTH words.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, heap word width; DATA_WIDTH >= ADDR_WIDTH, so a word holds a pointer.
REQ-003 The block SHALL have parameter HEAP_BASE, default 1, first allocatable address; address 0 is NIL and never allocated.
REQ-004 The block SHALL have ports, clock and reset first:
- clk  input  1  single clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block accepts a request this cycle.
- req_op  input  2  00 ALLOC_NUM, 01 ALLOC_CONS, 10 READ_CAR, 11 READ_CDR.
- req_arg0  input  DATA_WIDTH  number value (ALLOC_NUM), car (ALLOC_CONS), cell pointer (READs; low ADDR_WIDTH bits used).
- req_arg1  input  DATA_WIDTH  cdr (ALLOC_CONS); ignored otherwise.
- heap_clr  input  1  discard all cells, reset the bump pointer.
- rsp_valid  output  1  one-cycle response pulse; no backpressure.
- rsp_data  output  DATA_WIDTH  new cell pointer (allocs) or field value (reads).
- rsp_err  output  1  request failed; qualified by rsp_valid.
- heap_ptr  output  ADDR_WIDTH+1  next free address.

Function
REQ-005 The block SHALL hold a 2^ADDR_WIDTH x DATA_WIDTH single-port memory with synchronous 1-cycle read.
REQ-006 The cell layout SHALL be: number = header TYPE_NUMBER (0) at p, value at p+1; cons = header TYPE_CONS (1) at p, car at p+1, cdr at p+2.
REQ-007 The FSM states SHALL be IDLE, W0, W1, W2, RD_HDR, RD_CHK, RD_ADDR, RD_DATA and RESP.
REQ-008 The req_ready output SHALL be 1 only in IDLE with heap_clr=0; a request is accepted on the edge where req_valid and req_ready are both 1.
REQ-009 An ALLOC_NUM accepted at edge N SHALL write the header at edge N+1 and the value at edge N+2, with rsp_valid high in the following cycle and rsp_data = old heap_ptr.
REQ-010 An ALLOC_CONS accepted at edge N SHALL write header, car and cdr at edges N+1..N+3, with rsp_valid high in the following cycle.
REQ-011 A successful alloc SHALL advance heap_ptr by the cell size (2 or 3) in the RESP entry cycle.
REQ-012 An alloc SHALL report full when heap_ptr + size > 2^ADDR_WIDTH: no write, heap_ptr unchanged, RESP at edge N+1, rsp_err=1, rsp_data=0; the pointer never wraps.
REQ-013 A READ_CAR or READ_CDR SHALL read address ptr+1 or ptr+2, with rsp_valid high in the cycle after edge N+2 and rsp_data = the stored word.
REQ-014 A read of ptr=0 (NIL) SHALL go to RESP at edge N+1 with rsp_err=1 and rsp_data=0.
REQ-015 A read with ptr >= heap_ptr SHALL respond the same way as a NIL read.
REQ-016 In IDLE, heap_clr=1 SHALL set heap_ptr=HEAP_BASE at the next edge and block any simultaneous request, which is not accepted.
REQ-017 Outside IDLE, heap_clr SHALL be ignored.
REQ-018 RESP SHALL last exactly one cycle and then return to IDLE.
REQ-019 The rsp_data and rsp_err outputs SHALL hold their values until the next RESP.

Reset
REQ-020 Assertion of rst_n=0 SHALL immediately force state IDLE, rsp_valid=0, rsp_data=0, rsp_err=0 and heap_ptr=HEAP_BASE.
REQ-021 The req_ready output SHALL be 0 while rst_n=0.
REQ-022 Reset mid-operation SHALL abort without any response; words already written stay in memory, and memory is not cleared.

Configuration
REQ-023 With LISP_HEAP_TYPECHECK_EN defined, reads SHALL first read the header (RD_HDR, RD_CHK), adding 2 cycles to read latency, so rsp_valid follows edge N+4.
REQ-024 With LISP_HEAP_TYPECHECK_EN defined, a header != TYPE_CONS SHALL produce rsp_err=1 and rsp_data=0.
REQ-025 With LISP_HEAP_TYPECHECK_EN undefined, RD_HDR and RD_CHK SHALL be unreachable and no header check is made.

Verification
REQ-026 ALLOC_NUM arg0=0x002A after reset -> rsp_data=0x0001, rsp_err=0, heap_ptr=3, mem[1]=0, mem[2]=0x002A.
REQ-027 Then ALLOC_CONS car=0x0001 cdr=0x0000 -> rsp_data=0x0003, heap_ptr=6; READ_CDR 0x0003 -> 0x0000; READ_CAR 0x0003 -> 0x0001.
REQ-028 READ_CAR ptr=0 -> rsp_err=1, rsp_data=0, one cycle after acceptance.
REQ-029 ADDR_WIDTH=4 with heap_ptr=14, ALLOC_CONS -> rsp_err=1 and heap_ptr stays 14; ALLOC_NUM -> ok, rsp_data=14, heap_ptr=16.
REQ-030 heap_clr and req_valid in the same IDLE cycle -> no accept, heap_ptr=1 next cycle, request accepted the cycle after.
REQ-031 TYPECHECK_EN: READ_CAR 0x0001 on a number cell -> rsp_err=1 at N+4; rst_n pulsed during W1 of a cons alloc -> no rsp_valid, heap_ptr=1.
